// File: rtl/ram_bus_bridge.sv
// Bridges a valid/ready memory bus onto a single-port 1024x32 SRAM macro.
// Define RAM_BRIDGE_INIT_EN to clear the macro to INIT_VAL after every reset.
module ram_bus_bridge #(
    parameter logic [31:0] INIT_VAL = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        sram_cs_o,
    output logic        sram_wren_o,
    output logic [9:0]  sram_addr_o,
    output logic [31:0] sram_data_o,
    output logic [3:0]  sram_mask_o,
    input  logic [31:0] sram_data_i,
    output logic        init_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RD   = 2'd2,
        RESP = 2'd3
    } state_e;

`ifdef RAM_BRIDGE_INIT_EN
    localparam state_e RESET_STATE = INIT;
`else
    localparam state_e RESET_STATE = IDLE;
`endif

    state_e      state_q;
    logic        ready_q;
    logic [31:0] rdata_q;
    logic        is_write;
    logic        accept;

`ifdef RAM_BRIDGE_INIT_EN
    logic [9:0]  init_cnt_q;
    logic        init_done_q;
`endif

    assign is_write = (mem_wstrb_i != 4'h0);
    // Gated by reset so a request presented while reset is low never reaches the macro.
    assign accept   = rst_n_i && (state_q == IDLE) && mem_valid_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= RESET_STATE;
            ready_q     <= 1'b0;
            rdata_q     <= 32'h0000_0000;
`ifdef RAM_BRIDGE_INIT_EN
            init_cnt_q  <= 10'd0;
            init_done_q <= 1'b0;
`endif
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_valid_i) begin
                        if (is_write) begin
                            state_q <= RESP;
                            ready_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    // Macro read data is valid the cycle after the read strobe.
                    rdata_q <= sram_data_i;
                    state_q <= RESP;
                    ready_q <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                end
`ifdef RAM_BRIDGE_INIT_EN
                INIT: begin
                    if (&init_cnt_q) begin
                        state_q     <= IDLE;
                        init_done_q <= 1'b1;
                    end else begin
                        init_cnt_q  <= init_cnt_q + 10'd1;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        sram_cs_o   = 1'b0;
        sram_wren_o = 1'b0;
        sram_addr_o = mem_addr_i[11:2];
        sram_data_o = mem_wdata_i;
        sram_mask_o = 4'h0;
        if (accept) begin
            sram_cs_o   = 1'b1;
            sram_wren_o = is_write;
            sram_mask_o = mem_wstrb_i;
        end
`ifdef RAM_BRIDGE_INIT_EN
        if (rst_n_i && (state_q == INIT)) begin
            sram_cs_o   = 1'b1;
            sram_wren_o = 1'b1;
            sram_addr_o = init_cnt_q;
            sram_data_o = INIT_VAL;
            sram_mask_o = 4'hF;
        end
`endif
    end

    assign mem_ready_o = ready_q;
    assign mem_rdata_o = rdata_q;

`ifdef RAM_BRIDGE_INIT_EN
    assign init_done_o = init_done_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:12], mem_addr_i[1:0]};
`else
    assign init_done_o = 1'b1;

    // Only word-address bits matter; INIT_VAL has no effect without power-on clear.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr_i[31:12], mem_addr_i[1:0], INIT_VAL};
`endif

endmodule

// File: tb/tb_ram_bus_bridge.sv
// Directed self-checking bench for ram_bus_bridge with a behavioural SRAM macro.
// Build with RAM_BRIDGE_INIT_EN defined to also exercise the power-on clear.
module tb_ram_bus_bridge;

    typedef struct packed {
        logic        cs;
        logic        wren;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } snap_t;

    localparam logic [31:0] FILL = 32'hA5A5_A5A5;
`ifdef RAM_BRIDGE_INIT_EN
    localparam logic EXP_DONE_IN_RESET = 1'b0;
`else
    localparam logic EXP_DONE_IN_RESET = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_rdata;
    logic        sram_cs;
    logic        sram_wren;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_mask;
    logic [31:0] sram_rdata = '0;
    logic        init_done;

    int n_cmp = 0;
    int n_err = 0;
    int ready_pulses = 0;

    logic [31:0] sram_mem [0:1023];

    always #5 clk = ~clk;

    ram_bus_bridge #(.INIT_VAL(FILL)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mem_valid_i (mem_valid),
        .mem_ready_o (mem_ready),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_wstrb_i (mem_wstrb),
        .mem_rdata_o (mem_rdata),
        .sram_cs_o   (sram_cs),
        .sram_wren_o (sram_wren),
        .sram_addr_o (sram_addr),
        .sram_data_o (sram_wdata),
        .sram_mask_o (sram_mask),
        .sram_data_i (sram_rdata),
        .init_done_o (init_done)
    );

    // Synchronous single-port macro: masked byte writes, registered read data.
    always @(posedge clk) begin
        if (sram_cs === 1'b1) begin
            if (sram_wren === 1'b1) begin
                for (int b = 0; b < 4; b++)
                    if (sram_mask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    always @(negedge clk) if (mem_ready === 1'b1) ready_pulses++;

    task automatic wait_init_done();
        for (int c = 0; c < 1100; c++) begin
            if (init_done === 1'b1) break;
            @(negedge clk);
        end
        n_cmp++;
        if (init_done !== 1'b1) begin
            n_err++;
            $display("FAIL init_wait: init_done=%b required 1", init_done);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init_done();
    endtask

    // Drives one request and holds valid until ready; lat counts cycles after acceptance.
    task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, output logic [31:0] rdata,
                            output snap_t snap, output int lat);
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
        lat = -1; rdata = '0; snap = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                snap.cs = sram_cs; snap.wren = sram_wren; snap.addr = sram_addr;
                snap.data = sram_wdata; snap.mask = sram_mask;
            end
            if (mem_ready === 1'b1) begin
                lat = c; rdata = mem_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (mem_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", mem_ready); end
        n_cmp++; if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", mem_rdata); end
        n_cmp++; if (sram_cs !== 1'b0) begin n_err++; $display("FAIL rst_cs: got %b want 0", sram_cs); end
        n_cmp++; if (init_done !== EXP_DONE_IN_RESET) begin n_err++; $display("FAIL rst_done: got %b want %b", init_done, EXP_DONE_IN_RESET); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_init_done();
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        snap_t s;
        int lat;
        bus_xfer(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, s, lat);
        n_cmp++; if (s.cs !== 1'b1) begin n_err++; $display("FAIL wr_cs: got %b want 1", s.cs); end
        n_cmp++; if (s.wren !== 1'b1) begin n_err++; $display("FAIL wr_wren: got %b want 1", s.wren); end
        n_cmp++; if (s.addr !== 10'd4) begin n_err++; $display("FAIL wr_addr: got %0d want 4", s.addr); end
        n_cmp++; if (s.mask !== 4'hF) begin n_err++; $display("FAIL wr_mask: got %h want f", s.mask); end
        n_cmp++; if (s.data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_data: got %h want deadbeef", s.data); end
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL wr_latency: got %0d want 1", lat); end
        bus_xfer(32'h0000_0010, 32'h0, 4'h0, rd, s, lat);
        n_cmp++; if (s.cs !== 1'b1 || s.wren !== 1'b0) begin n_err++; $display("FAIL rd_strobe: cs=%b wren=%b want 1/0", s.cs, s.wren); end
        n_cmp++; if (s.mask !== 4'h0) begin n_err++; $display("FAIL rd_mask: got %h want 0", s.mask); end
        n_cmp++; if (s.addr !== 10'd4) begin n_err++; $display("FAIL rd_addr: got %0d want 4", s.addr); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rd_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        @(negedge clk);
        n_cmp++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rdata_hold_idle: got %h want deadbeef", mem_rdata); end
        bus_xfer(32'h0000_0014, 32'h1357_9BDF, 4'hF, rd, s, lat);
        n_cmp++; if (mem_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rdata_hold_write: got %h want deadbeef", mem_rdata); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] rd;
        snap_t s;
        int lat;
        bus_xfer(32'h0000_0020, 32'h1122_3344, 4'hF, rd, s, lat);
        bus_xfer(32'h0000_0020, 32'h00AA_0000, 4'b0100, rd, s, lat);
        n_cmp++; if (s.mask !== 4'b0100) begin n_err++; $display("FAIL strb_mask: got %b want 0100", s.mask); end
        bus_xfer(32'h0000_0020, 32'h0, 4'h0, rd, s, lat);
        n_cmp++; if (rd !== 32'h11AA_3344) begin n_err++; $display("FAIL strb_byte2: got %h want 11aa3344", rd); end
        bus_xfer(32'h0000_0020, 32'hFF00_00EE, 4'b1001, rd, s, lat);
        bus_xfer(32'h0000_0020, 32'h0, 4'h0, rd, s, lat);
        n_cmp++; if (rd !== 32'hFFAA_33EE) begin n_err++; $display("FAIL strb_bytes30: got %h want ffaa33ee", rd); end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] rd;
        snap_t s;
        int lat;
        bus_xfer(32'h0000_1008, 32'h5A5A_1234, 4'hF, rd, s, lat);
        n_cmp++; if (s.addr !== 10'd2) begin n_err++; $display("FAIL wrap_addr: got %0d want 2", s.addr); end
        bus_xfer(32'h0000_0008, 32'h0, 4'h0, rd, s, lat);
        n_cmp++; if (rd !== 32'h5A5A_1234) begin n_err++; $display("FAIL wrap_read: got %h want 5a5a1234", rd); end
        bus_xfer(32'h0000_000B, 32'h600D_D00D, 4'hF, rd, s, lat);
        bus_xfer(32'hFFFF_F008, 32'h0, 4'h0, rd, s, lat);
        n_cmp++; if (s.addr !== 10'd2) begin n_err++; $display("FAIL wrap_hi_addr: got %0d want 2", s.addr); end
        n_cmp++; if (rd !== 32'h600D_D00D) begin n_err++; $display("FAIL wrap_lowbits: got %h want 600dd00d", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] req_addr [4] = '{32'h40, 32'h40, 32'h44, 32'h44};
        logic [31:0] req_data [4] = '{32'hCAFE_F00D, 32'h0, 32'h0123_4567, 32'h0};
        logic [3:0]  req_strb [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
        logic [9:0]  cs_pat = '0;
        logic [9:0]  rdy_pat = '0;
        logic [31:0] rd1 = '0;
        logic [31:0] rd3 = '0;
        int k = 0;
        @(posedge clk); #1;
        mem_valid = 1'b1;
        mem_addr = req_addr[0]; mem_wdata = req_data[0]; mem_wstrb = req_strb[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cs_pat[c]  = sram_cs;
            rdy_pat[c] = mem_ready;
            if (mem_ready === 1'b1) begin
                if (k == 1) rd1 = mem_rdata;
                if (k == 3) rd3 = mem_rdata;
                k++;
            end
            @(posedge clk); #1;
            if (k < 4) begin
                mem_addr = req_addr[k]; mem_wdata = req_data[k]; mem_wstrb = req_strb[k];
            end else begin
                mem_valid = 1'b0; mem_wstrb = 4'h0;
            end
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        n_cmp++; if (cs_pat !== 10'b0010100101) begin n_err++; $display("FAIL b2b_cs_pattern: got %b want 0010100101", cs_pat); end
        n_cmp++; if (rdy_pat !== 10'b1001010010) begin n_err++; $display("FAIL b2b_ready_pattern: got %b want 1001010010", rdy_pat); end
        n_cmp++; if (k !== 4) begin n_err++; $display("FAIL b2b_completed: got %0d want 4", k); end
        n_cmp++; if (rd1 !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_read1: got %h want cafef00d", rd1); end
        n_cmp++; if (rd3 !== 32'h0123_4567) begin n_err++; $display("FAIL b2b_read3: got %h want 01234567", rd3); end
    endtask

    task automatic test_reset_in_rd();
        logic [31:0] rd;
        snap_t s;
        int lat;
        int pulses0;
        bus_xfer(32'h0000_0030, 32'h0BAD_C0DE, 4'hF, rd, s, lat);
        pulses0 = ready_pulses;
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_addr = 32'h30; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; mem_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL rstrd_rdata: got %h want 0", mem_rdata); end
        repeat (3) @(negedge clk);
        n_cmp++; if (ready_pulses !== pulses0) begin n_err++; $display("FAIL rstrd_no_ready: got %0d pulses want %0d", ready_pulses, pulses0); end
        wait_init_done();
        bus_xfer(32'h0000_0030, 32'h0, 4'h0, rd, s, lat);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL rstrd_latency: got %0d want 2", lat); end
`ifdef RAM_BRIDGE_INIT_EN
        n_cmp++; if (rd !== FILL) begin n_err++; $display("FAIL rstrd_data: got %h want a5a5a5a5", rd); end
`else
        n_cmp++; if (rd !== 32'h0BAD_C0DE) begin n_err++; $display("FAIL rstrd_data: got %h want 0badc0de", rd); end
`endif
    endtask

`ifdef RAM_BRIDGE_INIT_EN
    task automatic test_init();
        int busy = 0;
        int ready_in_init = 0;
        int lat = -1;
        logic [9:0] acc_addr = '0;
        logic acc_cs = 1'b0;
        logic [31:0] rd = '0;
        @(posedge clk); #1;
        rst_n = 1'b0; mem_valid = 1'b1; mem_addr = 32'h0000_0FFC; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (init_done === 1'b1) break;
            busy++;
            if (mem_ready === 1'b1) ready_in_init++;
        end
        acc_cs = sram_cs; acc_addr = sram_addr;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin lat = c + 1; rd = mem_rdata; break; end
        end
        @(posedge clk); #1;
        mem_valid = 1'b0;
        n_cmp++; if (busy !== 1024) begin n_err++; $display("FAIL init_cycles: got %0d want 1024", busy); end
        n_cmp++; if (ready_in_init !== 0) begin n_err++; $display("FAIL init_ready: got %0d want 0", ready_in_init); end
        n_cmp++; if (acc_cs !== 1'b1 || acc_addr !== 10'h3FF) begin n_err++; $display("FAIL init_accept: cs=%b addr=%h want 1/3ff", acc_cs, acc_addr); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL init_rd_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== FILL) begin n_err++; $display("FAIL init_fill: got %h want a5a5a5a5", rd); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_addr_wrap();
        test_back_to_back();
        test_reset_in_rd();
`ifdef RAM_BRIDGE_INIT_EN
        test_init();
`endif
        do_reset();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
